hdbn_decoder: RTL and testbench

- Parametrised HDBn line decoder for dual-rail bipolar input (P = positive mark, N = negative mark). It supersedes the fixed HDB3 violation checker.
- Detects V pulses, removes the complete substitution group (000V or B00V) and outputs recovered NRZ data.
- Flags rail, substitution and zero-run errors.
- Sits between the line-interface sampler and the frame/clock-recovery logic.

---
 rtl/hdbn_decoder.sv | 169 ++++++++++++++++
 tb/tb_hdbn_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hdbn_decoder.sv
// HDBn dual-rail line decoder: V detection, substitution removal, NRZ recovery, error flags.
// Define HDBN_ERR_CNT_EN to build the saturating error counter behind err_cnt/err_clr.
module hdbn_decoder #(
  parameter int N_ZERO    = 3,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sym_en,
  input  logic                 P,
  input  logic                 N,
  input  logic                 err_clr,
  output logic                 dout,
  output logic                 dout_vld,
  output logic                 v_det,
  output logic                 rail_err,
  output logic                 sub_err,
  output logic                 zero_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int L      = N_ZERO + 1;
  localparam int FILL_W = $clog2(L + 1);
  localparam int ZR_W   = $clog2(N_ZERO + 2);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(L);
  localparam logic [ZR_W-1:0]   ZR_LIM    = ZR_W'(N_ZERO);
  localparam logic [ZR_W-1:0]   ZR_SAT    = ZR_W'(N_ZERO + 1);

  typedef enum logic [1:0] {POL_NONE = 2'd0, POL_POS = 2'd1, POL_NEG = 2'd2} pol_e;

  // A V is legal when the preceding L-1 slots hold no mark, or only a B in the oldest slot.
  function automatic logic sub_legal(input logic [L-2:0] marks);
    logic [L-2:0] b_only;
    b_only      = '0;
    b_only[L-2] = 1'b1;
    return (marks == '0) || (marks == b_only);
  endfunction

  // Decoded bit and mark flag are always equal (V, zero and rail symbols enter as 0),
  // so one vector serves as both; bit 0 is the youngest entry.
  logic [L-1:0]      line_r, line_s;
  pol_e              last_pol_r, last_pol_s;
  logic [ZR_W-1:0]   zero_run_r, zero_run_s;
  logic [FILL_W-1:0] fill_r, fill_s;
  logic              mark_s, rail_s, v_s, filled_s;
  logic              dout_r, dout_vld_r, v_det_r, rail_err_r, sub_err_r, zero_err_r;
  logic              dout_s, dout_vld_s, v_det_s, rail_err_s, sub_err_s, zero_err_s;

  // Symbol classification and polarity-violation detection
  always_comb begin
    rail_s   = P & N;
    mark_s   = P ^ N;
    filled_s = (fill_r == FILL_FULL);
    v_s      = 1'b0;
    if (mark_s) begin
      case (last_pol_r)
        POL_POS: v_s = P;
        POL_NEG: v_s = ~P;
        default: v_s = 1'b0;
      endcase
    end else begin
      v_s = 1'b0;
    end
  end

  // Next state of the delay line, trackers and pulse outputs
  always_comb begin
    line_s     = line_r;
    last_pol_s = last_pol_r;
    zero_run_s = zero_run_r;
    fill_s     = fill_r;
    dout_s     = 1'b0;
    dout_vld_s = 1'b0;
    v_det_s    = 1'b0;
    rail_err_s = 1'b0;
    sub_err_s  = 1'b0;
    zero_err_s = 1'b0;
    if (sym_en) begin
      dout_vld_s = filled_s;
      dout_s     = filled_s & line_r[L-1];
      v_det_s    = v_s;
      rail_err_s = rail_s;
      sub_err_s  = v_s & ~sub_legal(line_r[L-2:0]);
      zero_err_s = ~mark_s & (zero_run_r == ZR_LIM);
      // Clearing the L-1 younger entries then shifting in the V's 0 empties the whole line.
      if (v_s) begin
        line_s = '0;
      end else begin
        line_s = {line_r[L-2:0], mark_s};
      end
      if (mark_s) begin
        last_pol_s = P ? POL_POS : POL_NEG;
        zero_run_s = '0;
      end else if (zero_run_r == ZR_SAT) begin
        zero_run_s = zero_run_r;
      end else begin
        zero_run_s = zero_run_r + ZR_W'(1);
      end
      if (filled_s) begin
        fill_s = fill_r;
      end else begin
        fill_s = fill_r + FILL_W'(1);
      end
    end else begin
      line_s = line_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_r     <= '0;
      last_pol_r <= POL_NONE;
      zero_run_r <= '0;
      fill_r     <= '0;
      dout_r     <= 1'b0;
      dout_vld_r <= 1'b0;
      v_det_r    <= 1'b0;
      rail_err_r <= 1'b0;
      sub_err_r  <= 1'b0;
      zero_err_r <= 1'b0;
    end else begin
      line_r     <= line_s;
      last_pol_r <= last_pol_s;
      zero_run_r <= zero_run_s;
      fill_r     <= fill_s;
      dout_r     <= dout_s;
      dout_vld_r <= dout_vld_s;
      v_det_r    <= v_det_s;
      rail_err_r <= rail_err_s;
      sub_err_r  <= sub_err_s;
      zero_err_r <= zero_err_s;
    end
  end

  assign dout     = dout_r;
  assign dout_vld = dout_vld_r;
  assign v_det    = v_det_r;
  assign rail_err = rail_err_r;
  assign sub_err  = sub_err_r;
  assign zero_err = zero_err_r;

`ifdef HDBN_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic                 any_err_s;

  assign any_err_s = rail_err_s | sub_err_s | zero_err_s;

  // Saturating error counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= '0;
    end else if (err_clr) begin
      err_cnt_r <= '0;
    end else if (any_err_s && (err_cnt_r != '1)) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  logic unused_err_clr_s;

  assign unused_err_clr_s = err_clr;
  assign err_cnt          = '0;
`endif

endmodule

// File: tb/tb_hdbn_decoder.sv
// Scoreboard bench for hdbn_decoder: HDB3 instance (index 0) and HDB2 instance (index 1).
module tb_hdbn_decoder;
  localparam logic [1:0] PL = 2'b10;
  localparam logic [1:0] MI = 2'b01;
  localparam logic [1:0] ZE = 2'b00;
  localparam logic [1:0] RL = 2'b11;

  typedef struct packed {
    int          id;
    logic [5:0]  x;    // {vld, dout, v_det, rail_err, sub_err, zero_err}
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en, p, n, clr;
  wire  [1:0]  dout_w, vld_w, v_w, rail_w, sub_w, zero_w;
  wire  [15:0] cnt0_w, cnt1_w;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] ecnt [2];
  int          checks = 0;
  int          failures = 0;
  int          sid = 0;

  logic [1:0] t1_pn [10] = '{PL, ZE, ZE, ZE, PL, MI, PL, MI, PL, MI};
  logic [5:0] t1_x  [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b111000,
                             6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b110000};

  always #5 clk = ~clk;

  hdbn_decoder #(.N_ZERO(3), .ERR_CNT_W(16)) u_hdb3 (
    .clk(clk), .rst_n(rst_n), .sym_en(en[0]), .P(p[0]), .N(n[0]), .err_clr(clr[0]),
    .dout(dout_w[0]), .dout_vld(vld_w[0]), .v_det(v_w[0]), .rail_err(rail_w[0]),
    .sub_err(sub_w[0]), .zero_err(zero_w[0]), .err_cnt(cnt0_w)
  );

  hdbn_decoder #(.N_ZERO(2), .ERR_CNT_W(16)) u_hdb2 (
    .clk(clk), .rst_n(rst_n), .sym_en(en[1]), .P(p[1]), .N(n[1]), .err_clr(clr[1]),
    .dout(dout_w[1]), .dout_vld(vld_w[1]), .v_det(v_w[1]), .rail_err(rail_w[1]),
    .sub_err(sub_w[1]), .zero_err(zero_w[1]), .err_cnt(cnt1_w)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic compare(input int d, input exp_t r);
    string tag;
    tag = $sformatf("dut%0d_step%0d", d, r.id);
    chk({tag, "_vld"},  16'(vld_w[d]),  16'(r.x[5]));
    chk({tag, "_vdet"}, 16'(v_w[d]),    16'(r.x[3]));
    chk({tag, "_rail"}, 16'(rail_w[d]), 16'(r.x[2]));
    chk({tag, "_sub"},  16'(sub_w[d]),  16'(r.x[1]));
    chk({tag, "_zero"}, 16'(zero_w[d]), 16'(r.x[0]));
    if (r.x[5]) begin
      chk({tag, "_dout"}, 16'(dout_w[d]), 16'(r.x[4]));
    end
    chk({tag, "_cnt"}, (d == 0) ? cnt0_w : cnt1_w, r.cnt);
  endtask

  // One clock cycle of stimulus on DUT d; the expected outputs after the next edge are queued.
  task automatic step(input int d, input logic [1:0] pn, input logic e, input logic c,
                      input logic [5:0] x);
    exp_t r;
    @(negedge clk);
    en = 2'b00; clr = 2'b00; p = 2'b00; n = 2'b00;
    en[d] = e; clr[d] = c; p[d] = pn[1]; n[d] = pn[0];
`ifdef HDBN_ERR_CNT_EN
    if (c) ecnt[d] = 16'd0;
    else if (e && (x[2] | x[1] | x[0]) && (ecnt[d] != 16'hFFFF)) ecnt[d] = ecnt[d] + 16'd1;
`endif
    sid++;
    r.id = sid; r.x = x; r.cnt = ecnt[d];
    if (d == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic sym(input int d, input logic [1:0] pn, input logic [5:0] x);
    step(d, pn, 1'b1, 1'b0, x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 2'b00; clr = 2'b00; p = 2'b00; n = 2'b00;
    ecnt[0] = 16'd0; ecnt[1] = 16'd0;
    #1;
    chk("reset_flags", 16'({dout_w, vld_w, v_w, rail_w, sub_w, zero_w}), 16'd0);
    chk("reset_cnt0", cnt0_w, 16'd0);
    chk("reset_cnt1", cnt1_w, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops the expectation for each driven cycle just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) compare(0, q0.pop_front());
      if (q1.size() != 0) compare(1, q1.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    en = 2'b00; clr = 2'b00; p = 2'b00; n = 2'b00;
    ecnt[0] = 16'd0; ecnt[1] = 16'd0;
    do_reset();

    // HDB3 000V
    for (int i = 0; i < 10; i++) sym(0, t1_pn[i], t1_x[i]);

    // HDB3 B00V
    do_reset();
    sym(0, PL, 6'b000000); sym(0, ZE, 6'b000000); sym(0, ZE, 6'b000000); sym(0, ZE, 6'b000000);
    sym(0, PL, 6'b111000); sym(0, MI, 6'b100000); sym(0, ZE, 6'b100000); sym(0, ZE, 6'b100000);
    sym(0, MI, 6'b101000); sym(0, PL, 6'b100000); sym(0, MI, 6'b100000); sym(0, PL, 6'b100000);
    sym(0, MI, 6'b100000); sym(0, PL, 6'b110000);

    // Illegal V after a single zero; the first + is cleared from the line
    do_reset();
    sym(0, PL, 6'b000000); sym(0, ZE, 6'b000000); sym(0, PL, 6'b001010); sym(0, ZE, 6'b000000);
    sym(0, MI, 6'b100000); sym(0, PL, 6'b100000); sym(0, MI, 6'b100000); sym(0, PL, 6'b100000);
    sym(0, MI, 6'b110000);

    // Rail error, zero run overflow, counter clear and clear-over-increment priority
    do_reset();
    sym(0, PL, 6'b000000); sym(0, RL, 6'b000100); sym(0, MI, 6'b000000); sym(0, ZE, 6'b000000);
    sym(0, ZE, 6'b110000); sym(0, ZE, 6'b100000); sym(0, ZE, 6'b110001); sym(0, ZE, 6'b100000);
    sym(0, PL, 6'b100000); sym(0, MI, 6'b100000); sym(0, PL, 6'b100000); sym(0, MI, 6'b100000);
    step(0, ZE, 1'b0, 1'b1, 6'b000000);
    step(0, RL, 1'b1, 1'b1, 6'b110100);
    sym(0, RL, 6'b110100);

    // Gapped strobes: idle cycles carry junk on both rails and must produce nothing
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sym(0, t1_pn[i], t1_x[i]);
      step(0, RL, 1'b0, 1'b0, 6'b000000);
      step(0, RL, 1'b0, 1'b0, 6'b000000);
    end

    // Reset mid-stream while pulses are high; next + after reset is a normal mark
    do_reset();
    sym(0, PL, 6'b000000); sym(0, ZE, 6'b000000); sym(0, ZE, 6'b000000); sym(0, ZE, 6'b000000);
    sym(0, PL, 6'b111000);
    do_reset();
    sym(0, PL, 6'b000000); sym(0, MI, 6'b000000); sym(0, PL, 6'b000000); sym(0, MI, 6'b000000);
    sym(0, PL, 6'b110000);

    // HDB2: 00V, then B0V clearing two slots
    do_reset();
    sym(1, PL, 6'b000000); sym(1, ZE, 6'b000000); sym(1, ZE, 6'b000000); sym(1, PL, 6'b111000);
    sym(1, MI, 6'b100000); sym(1, PL, 6'b100000); sym(1, MI, 6'b100000);
    sym(1, PL, 6'b110000); sym(1, MI, 6'b110000); sym(1, ZE, 6'b110000); sym(1, MI, 6'b111000);
    sym(1, PL, 6'b100000); sym(1, MI, 6'b100000); sym(1, PL, 6'b100000);

    // HDB2: third zero overflows the run
    do_reset();
    sym(1, PL, 6'b000000); sym(1, ZE, 6'b000000); sym(1, ZE, 6'b000000); sym(1, ZE, 6'b110001);
    sym(1, MI, 6'b100000); sym(1, PL, 6'b100000); sym(1, MI, 6'b100000);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 16'(q0.size() + q1.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
